// File: rtl/sumador_serie_n_bit_if.sv
// sumador_serie_n_bit_if: request/result bundle for the bit-serial adder (RESTA present only with SUMADOR_RESTA_EN)
interface sumador_serie_n_bit_if #(parameter int N = 4);
    logic         inicio;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         CIN;
`ifdef SUMADOR_RESTA_EN
    logic         RESTA;
`endif
    logic         ocupado;
    logic         hecho;
    logic [N-1:0] S;
    logic         COUT;
    logic         DESBORDE;
`ifdef SUMADOR_RESTA_EN
    modport master (output inicio, A, B, CIN, RESTA, input ocupado, hecho, S, COUT, DESBORDE);
    modport slave  (input inicio, A, B, CIN, RESTA, output ocupado, hecho, S, COUT, DESBORDE);
`else
    modport master (output inicio, A, B, CIN, input ocupado, hecho, S, COUT, DESBORDE);
    modport slave  (input inicio, A, B, CIN, output ocupado, hecho, S, COUT, DESBORDE);
`endif
endinterface

// File: rtl/sumador_serie_n_bit.sv
// sumador_serie_n_bit: N-bit serial adder, one bit per cycle LSB first; SUMADOR_RESTA_EN adds a subtract mode
module sumador_serie_n_bit #(
    parameter int N = 4
) (
    input logic               clk,
    input logic               rst_n,
    sumador_serie_n_bit_if.slave bus
);
    localparam int CW = $clog2(N + 1);
    typedef enum logic [1:0] {REPOSO, SUMANDO, FIN} estado_t;
    estado_t       estado_q, estado_d;
    logic [N-1:0]  a_q, a_d, b_q, b_d, res_q, res_d, s_q, s_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d, cout_q, cout_d, desb_q, desb_d;
    logic          suma, acarreo;
    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= REPOSO;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            s_q      <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            desb_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            desb_q   <= desb_d;
        end
    end
    // Next state: operands shift right so bit 0 is always the current bit; sum bits enter the result at the top
    always_comb begin
        estado_d = estado_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        desb_d   = desb_q;
        suma     = a_q[0] ^ b_q[0] ^ carry_q;
        acarreo  = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
        case (estado_q)
            REPOSO: begin
                if (bus.inicio) begin
                    a_d      = bus.A;
`ifdef SUMADOR_RESTA_EN
                    b_d      = bus.RESTA ? ~bus.B : bus.B;
                    carry_d  = bus.RESTA ? ~bus.CIN : bus.CIN;
`else
                    b_d      = bus.B;
                    carry_d  = bus.CIN;
`endif
                    res_d    = '0;
                    cnt_d    = '0;
                    estado_d = SUMANDO;
                end
            end
            SUMANDO: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = (res_q >> 1) | (N'(suma) << (N - 1));
                carry_d = acarreo;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    s_d      = res_d;
                    cout_d   = acarreo;
                    desb_d   = carry_q ^ acarreo;
                    estado_d = FIN;
                end
            end
            FIN:     estado_d = REPOSO;
            default: estado_d = REPOSO;
        endcase
    end
    assign bus.ocupado  = estado_q != REPOSO;
    assign bus.hecho    = estado_q == FIN;
    assign bus.S        = s_q;
    assign bus.COUT     = cout_q;
    assign bus.DESBORDE = desb_q;
endmodule

// File: tb/tb_sumador_serie_n_bit.sv
// tb_sumador_serie_n_bit: directed checks of the serial adder at N=4 and N=1
module tb_sumador_serie_n_bit;
    logic clk = 1'b0;
    logic rst_n;
    int   errs = 0;
    int   checks = 0;
    sumador_serie_n_bit_if #(.N(4)) if4 ();
    sumador_serie_n_bit_if #(.N(1)) if1 ();
    sumador_serie_n_bit #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    sumador_serie_n_bit #(.N(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    always #5 clk = ~clk;
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    initial begin
        rst_n = 1'b0;
        if4.inicio = 0; if4.A = 0; if4.B = 0; if4.CIN = 0;
        if1.inicio = 0; if1.A = 0; if1.B = 0; if1.CIN = 0;
`ifdef SUMADOR_RESTA_EN
        if4.RESTA = 0; if1.RESTA = 0;
`endif
        tick(2);
        chk("rst_S", if4.S, 0);
        chk("rst_COUT", if4.COUT, 0);
        chk("rst_DESBORDE", if4.DESBORDE, 0);
        chk("rst_hecho", if4.hecho, 0);
        chk("rst_ocupado", if4.ocupado, 0);
        // 0101 + 0011, accepted on the first edge after reset release
        if4.A = 4'b0101; if4.B = 4'b0011; if4.CIN = 0; if4.inicio = 1;
        rst_n = 1'b1;
        tick();
        if4.inicio = 0;
        chk("a_ocupado", if4.ocupado, 1);
        tick(3);
        chk("a_hecho_early", if4.hecho, 0);
        tick();
        chk("a_hecho", if4.hecho, 1);
        chk("a_S", if4.S, 4'b1000);
        chk("a_COUT", if4.COUT, 0);
        chk("a_DESBORDE", if4.DESBORDE, 1);
        tick();
        chk("a_hecho_pulse", if4.hecho, 0);
        chk("a_ocupado_end", if4.ocupado, 0);
        // 1111 + 0001 + 1, previous S held during computation
        if4.A = 4'b1111; if4.B = 4'b0001; if4.CIN = 1; if4.inicio = 1;
        tick();
        if4.inicio = 0;
        tick(2);
        chk("b_S_held", if4.S, 4'b1000);
        tick();
        chk("b_hecho_early", if4.hecho, 0);
        tick();
        chk("b_hecho", if4.hecho, 1);
        chk("b_S", if4.S, 4'b0001);
        chk("b_COUT", if4.COUT, 1);
        chk("b_DESBORDE", if4.DESBORDE, 0);
        tick();
        // inicio held, operands changed mid-flight
        if4.A = 4'b0010; if4.B = 4'b0011; if4.CIN = 0; if4.inicio = 1;
        tick();
        if4.A = 4'b1111; if4.B = 4'b1111;
        tick(3);
        chk("c_S_held", if4.S, 4'b0001);
        tick();
        chk("c_hecho", if4.hecho, 1);
        chk("c_S", if4.S, 4'b0101);
        chk("c_COUT", if4.COUT, 0);
        chk("c_DESBORDE", if4.DESBORDE, 0);
        tick();
        chk("c_ocupado_reposo", if4.ocupado, 0);
        tick();
        chk("c_reaccept", if4.ocupado, 1);
        if4.inicio = 0;
        tick(3);
        chk("c2_hecho_early", if4.hecho, 0);
        tick();
        chk("c2_hecho", if4.hecho, 1);
        chk("c2_S", if4.S, 4'b1110);
        chk("c2_COUT", if4.COUT, 1);
        chk("c2_DESBORDE", if4.DESBORDE, 0);
        tick();
        // reset mid-operation after bit 2
        if4.A = 4'b1010; if4.B = 4'b0110; if4.CIN = 0; if4.inicio = 1;
        tick();
        if4.inicio = 0;
        tick(3);
        rst_n = 1'b0;
        #1;
        chk("r_S", if4.S, 0);
        chk("r_COUT", if4.COUT, 0);
        chk("r_DESBORDE", if4.DESBORDE, 0);
        chk("r_ocupado", if4.ocupado, 0);
        chk("r_hecho", if4.hecho, 0);
        tick(2);
        chk("r_hecho_hold", if4.hecho, 0);
        if4.A = 4'b0001; if4.B = 4'b0001; if4.CIN = 0; if4.inicio = 1;
        rst_n = 1'b1;
        tick();
        if4.inicio = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("r2_no_hecho", if4.hecho, 0);
        end
        tick();
        chk("r2_hecho", if4.hecho, 1);
        chk("r2_S", if4.S, 4'b0010);
        tick();
        // single-bit instance: 1 + 1 + 1
        if1.A = 1'b1; if1.B = 1'b1; if1.CIN = 1; if1.inicio = 1;
        tick();
        if1.inicio = 0;
        chk("n1_hecho_early", if1.hecho, 0);
        tick();
        chk("n1_hecho", if1.hecho, 1);
        chk("n1_S", if1.S, 1);
        chk("n1_COUT", if1.COUT, 1);
        chk("n1_DESBORDE", if1.DESBORDE, 0);
        tick();
        chk("n1_ocupado_end", if1.ocupado, 0);
`ifdef SUMADOR_RESTA_EN
        // 0011 - 0101 - 0
        if4.A = 4'b0011; if4.B = 4'b0101; if4.CIN = 0; if4.RESTA = 1; if4.inicio = 1;
        tick();
        if4.inicio = 0; if4.RESTA = 0;
        tick(4);
        chk("s_hecho", if4.hecho, 1);
        chk("s_S", if4.S, 4'b1110);
        chk("s_COUT", if4.COUT, 0);
        chk("s_DESBORDE", if4.DESBORDE, 0);
        tick();
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/sumador_serie_n_bit.md
SUMADOR_SERIE_N_BIT -- requirements
Module: sumador_serie_n_bit

Interface
REQ-001 SHALL have parameter N, default 4, meaning operand/result width in bits; legal range 1..32.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port inicio, input, 1, start request; sampled only in state REPOSO.
REQ-005 SHALL have port A, input, N, first operand, captured at accept.
REQ-006 SHALL have port B, input, N, second operand, captured at accept.
REQ-007 SHALL have port CIN, input, 1, carry-in, captured at accept.
REQ-008 SHALL have port ocupado, output, 1, high whenever state is not REPOSO.
REQ-009 SHALL have port hecho, output, 1, one-cycle pulse marking a new valid result.
REQ-010 SHALL have port S, output, N, registered sum.
REQ-011 SHALL have port COUT, output, 1, registered carry-out of bit N-1.
REQ-012 SHALL have port DESBORDE, output, 1, registered two's-complement overflow flag.

Function
REQ-013 SHALL implement FSM states REPOSO, SUMANDO, FIN.
REQ-014 SHALL accept in REPOSO when inicio=1 at a rising edge: capture A, B, carry register <= CIN, bit counter <= 0, go to SUMANDO.
REQ-015 SHALL, in each SUMANDO cycle, compute one full-adder bit LSB first from the captured operand bits and carry register, shift the sum bit into an internal result register, update the carry register, and increment the counter.
REQ-016 SHALL, on the edge processing bit N-1, load S from the internal result register, COUT from the final carry, DESBORDE = carry into bit N-1 XOR carry out of bit N-1, and go to FIN.
REQ-017 SHALL assert hecho only while in FIN (exactly one cycle), then return to REPOSO on the next edge.
REQ-018 Latency: accept at edge k -> S/COUT/DESBORDE updated and hecho high after edge k+N; ocupado low again after edge k+N+1.
REQ-019 SHALL ignore inicio in SUMANDO and FIN; no queuing, no effect on the operation in flight.
REQ-020 SHALL hold S, COUT, DESBORDE stable from one FIN update to the next, including throughout a following computation.
REQ-021 SHALL hold inicio=1 continuously as back-to-back requests: a new accept occurs on the first edge in REPOSO.
REQ-022 SHALL never let A, B or CIN changes after accept affect the result.
REQ-023 SHALL produce S = (A + B + CIN) mod 2^N and COUT = bit N of that sum.

Reset
REQ-024 SHALL, on rst_n low, immediately force state REPOSO, S=0, COUT=0, DESBORDE=0, hecho=0, ocupado=0, clear counter, carry and internal registers.
REQ-025 SHALL abandon any operation in flight when reset asserts mid-operation; no hecho pulse for it.
REQ-026 SHALL accept inicio on the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL, with macro SUMADOR_RESTA_EN defined, add input port RESTA (1 bit, captured at accept); when RESTA=1 the block computes A - B - CIN by capturing ~B and initialising carry to ~CIN; COUT then means no-borrow; DESBORDE uses the same rule as REQ-016.
REQ-028 SHALL, without SUMADOR_RESTA_EN, have no RESTA port and always add.

Verification
REQ-029 N=4, A=0101, B=0011, CIN=0, inicio pulse at edge k -> hecho high after edge k+4, S=1000, COUT=0, DESBORDE=1.
REQ-030 N=4, A=1111, B=0001, CIN=1 -> S=0001, COUT=1, DESBORDE=0; previous S held unchanged until this hecho.
REQ-031 N=4, inicio=1 held and A/B toggled during SUMANDO -> single result from first-captured operands, next accept on first REPOSO edge.
REQ-032 N=4, rst_n low after bit 2 of A=1010,B=0110 -> all outputs 0 immediately, no hecho; then A=0001,B=0001,CIN=0 -> S=0010.
REQ-033 SUMADOR_RESTA_EN defined, N=4, RESTA=1, A=0011, B=0101, CIN=0 -> S=1110, COUT=0, DESBORDE=0.
REQ-034 N=1, A=1, B=1, CIN=1 -> S=1, COUT=1, DESBORDE=0, hecho after edge k+1.
